ncpu32k_wb_queue: RTL and testbench
===================================

NCPU32K_WB_QUEUE -- requirements
Module: ncpu32k_wb_queue

Interface
REQ-001 SHALL have parameter AW, default 5, register address width (matches NCPU_REG_AW).
REQ-002 SHALL have parameter DW, default 32, data width (matches NCPU_DW).
REQ-003 SHALL have parameter DEPTH, default 4, entry count; power of two, >= 2.
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_1_valid  input  1  older result present.
REQ-007 in_1_addr  input  AW  older result destination register.
REQ-008 in_1_dat  input  DW  older result value.
REQ-009 in_2_valid, in_2_addr, in_2_dat  input  1/AW/DW  younger result, same meaning.
REQ-010 in_ready  output  1  queue accepts both slots this cycle.
REQ-011 arf_1_we, arf_1_waddr, arf_1_wdat  output  1/AW/DW  regfile write port 1.
REQ-012 arf_2_we, arf_2_waddr, arf_2_wdat  output  1/AW/DW  regfile write port 2.
REQ-013 wbq_empty  output  1  no entries held.

Function
REQ-014 SHALL store entries {addr, dat} in a circular FIFO of DEPTH entries, head/tail pointers wrapping modulo DEPTH, count 0..DEPTH.
REQ-015 in_ready SHALL be 1 iff (DEPTH - count) >= 2, from registered count only; same-cycle dequeues not credited.
REQ-016 Handshake: slot k accepted on a rising edge iff in_ready=1 and in_k_valid=1; in_ready SHALL NOT depend on in_*_valid.
REQ-017 Accepted slot with addr=0 SHALL be discarded (no entry consumed); nil register never written.
REQ-018 Order: when both slots enqueue, slot 1 SHALL occupy the lower (older) position; in_2_valid alone SHALL enqueue as a single entry.
REQ-019 Enqueue of 0, 1 or 2 entries per cycle: tail += number enqueued.
REQ-020 arf_1_we SHALL be 1 iff count>=1; arf_1_waddr/wdat = entry at head.
REQ-021 arf_2_we SHALL be 1 iff count>=2 and entry[head+1].addr != entry[head].addr; arf_2_waddr/wdat = entry at head+1 (wrapped).
REQ-022 WAW guard: same-address heads SHALL drain one per cycle, older first, so the younger value is the final regfile content.
REQ-023 Dequeue: head += arf_1_we + arf_2_we at each rising edge; regfile consumes unconditionally (no backpressure).
REQ-024 Latency: entry accepted at edge N SHALL appear on an arf port no earlier than cycle after edge N; with empty queue, exactly that cycle.
REQ-025 Simultaneous enqueue and dequeue SHALL update count = count + enq - deq in one edge.
REQ-026 When arf_k_we=0, arf_k_waddr/wdat are don't-care, but SHALL NOT be X after reset.
REQ-027 wbq_empty = (count==0).

Reset
REQ-028 rst=1 at a rising edge SHALL set head=tail=count=0, regardless of traffic in flight; pending entries and same-cycle inputs are dropped.
REQ-029 During and after reset: in_ready=1, arf_1_we=arf_2_we=0, wbq_empty=1.
REQ-030 Entry storage need not be reset; output address/data SHALL read as 0 while empty.

Verification
REQ-031 Empty queue, in_1 {r3,0xA}, in_2 {r4,0xB} one cycle -> next cycle arf_1 {we=1,r3,0xA}, arf_2 {we=1,r4,0xB}; following cycle both we=0, wbq_empty=1.
REQ-032 in_1 {r5,0x1}, in_2 {r5,0x2} -> cycle 1 only arf_1 {r5,0x1}, arf_2_we=0; cycle 2 arf_1 {r5,0x2}; regfile model ends r5=0x2.
REQ-033 in_1 {r0,0xFF}, in_2 {r7,0x9} -> only r7 written, via arf_1; r0 never on any port.
REQ-034 DEPTH=4, inject 2 same-address pairs back-to-back -> count reaches 3 then in_ready=0 the cycle count>2; no accepted entry lost, write order preserved across pointer wrap.
REQ-035 Queue holding 3 entries, assert rst for one cycle with in_*_valid=1 -> next cycle count=0, wbq_empty=1, no arf write of any pre-reset or same-cycle entry.
REQ-036 Random stimulus 10k cycles vs. reference scoreboard -> final regfile model equals in-order application of all non-r0 accepted results.

Source files
------------

// File: rtl/ncpu32k_wb_queue.sv
// rtl/ncpu32k_wb_queue.sv - dual-issue writeback queue feeding a two-port register file
// Entries drain in order, two per cycle unless the two oldest target the same register.

module ncpu32k_wb_queue #(
    parameter int AW    = 5,
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_1_valid,
    input  logic [AW-1:0] in_1_addr,
    input  logic [DW-1:0] in_1_dat,
    input  logic          in_2_valid,
    input  logic [AW-1:0] in_2_addr,
    input  logic [DW-1:0] in_2_dat,
    output logic          in_ready,
    output logic          arf_1_we,
    output logic [AW-1:0] arf_1_waddr,
    output logic [DW-1:0] arf_1_wdat,
    output logic          arf_2_we,
    output logic [AW-1:0] arf_2_waddr,
    output logic [DW-1:0] arf_2_wdat,
    output logic          wbq_empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;

    logic [AW-1:0] addr_mem [DEPTH];
    logic [DW-1:0] dat_mem  [DEPTH];

    logic [PW-1:0] head_1;
    logic [PW-1:0] tail_1;
    logic          take_1;
    logic          take_2;
    logic [1:0]    enq;
    logic [1:0]    deq;

    assign head_1 = head + 1'b1;
    assign tail_1 = tail + 1'b1;

    // Readiness comes from the registered count alone so it never waits on this cycle's drain.
    assign in_ready  = (count <= CW'(DEPTH - 2));
    assign wbq_empty = (count == '0);

    // Writes to the nil register are accepted but never occupy an entry.
    assign take_1 = in_ready && in_1_valid && (in_1_addr != '0);
    assign take_2 = in_ready && in_2_valid && (in_2_addr != '0);
    assign enq    = {1'b0, take_1} + {1'b0, take_2};

    // Second port only fires when it cannot race the first port onto the same register.
    assign arf_1_we = (count != '0);
    assign arf_2_we = (count >= CW'(2)) && (addr_mem[head_1] != addr_mem[head]);
    assign deq      = {1'b0, arf_1_we} + {1'b0, arf_2_we};

    assign arf_1_waddr = arf_1_we ? addr_mem[head]   : '0;
    assign arf_1_wdat  = arf_1_we ? dat_mem[head]    : '0;
    assign arf_2_waddr = arf_2_we ? addr_mem[head_1] : '0;
    assign arf_2_wdat  = arf_2_we ? dat_mem[head_1]  : '0;

    always_ff @(posedge clk) begin
        if (take_1) begin
            addr_mem[tail] <= in_1_addr;
            dat_mem[tail]  <= in_1_dat;
        end
        if (take_2) begin
            addr_mem[take_1 ? tail_1 : tail] <= in_2_addr;
            dat_mem[take_1 ? tail_1 : tail]  <= in_2_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PW'(deq);
            tail  <= tail + PW'(enq);
            count <= count + CW'(enq) - CW'(deq);
        end
    end

endmodule

// File: tb/tb_ncpu32k_wb_queue.sv
// tb/tb_ncpu32k_wb_queue.sv - queue-model scoreboard bench for ncpu32k_wb_queue
// A plain SV queue stands in for the FIFO; two register-file images are compared at the end.

module tb_ncpu32k_wb_queue;

    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_1_valid, in_2_valid;
    logic [AW-1:0] in_1_addr, in_2_addr;
    logic [DW-1:0] in_1_dat, in_2_dat;
    logic          in_ready;
    logic          arf_1_we, arf_2_we;
    logic [AW-1:0] arf_1_waddr, arf_2_waddr;
    logic [DW-1:0] arf_1_wdat, arf_2_wdat;
    logic          wbq_empty;

    ncpu32k_wb_queue #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_1_valid(in_1_valid), .in_1_addr(in_1_addr), .in_1_dat(in_1_dat),
        .in_2_valid(in_2_valid), .in_2_addr(in_2_addr), .in_2_dat(in_2_dat),
        .in_ready(in_ready),
        .arf_1_we(arf_1_we), .arf_1_waddr(arf_1_waddr), .arf_1_wdat(arf_1_wdat),
        .arf_2_we(arf_2_we), .arf_2_waddr(arf_2_waddr), .arf_2_wdat(arf_2_wdat),
        .wbq_empty(wbq_empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          q[$];
    logic [DW-1:0] reg_exp [32];
    logic [DW-1:0] reg_dut [32];
    int            errors = 0;
    int            checks = 0;
    bit            en = 1'b0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: occupancy is q.size(); the head pair drains unless it shares a register.
    always @(posedge clk) begin
        int  n;
        bit  e1, e2, rdy;
        if (rst) begin
            q.delete();
        end else begin
            n   = q.size();
            rdy = (DEPTH - n) >= 2;
            e1  = n >= 1;
            e2  = (n >= 2) && (q[1].a != q[0].a);
            if (e1) reg_exp[q[0].a] = q[0].d;
            if (e2) reg_exp[q[1].a] = q[1].d;
            if (e1) void'(q.pop_front());
            if (e2) void'(q.pop_front());
            if (rdy && in_1_valid && in_1_addr != 0) q.push_back('{in_1_addr, in_1_dat});
            if (rdy && in_2_valid && in_2_addr != 0) q.push_back('{in_2_addr, in_2_dat});
        end
    end

    always @(negedge clk) begin
        int n;
        bit e2;
        if (en) begin
            n  = q.size();
            e2 = (n >= 2) && (q[1].a != q[0].a);
            chk("in_ready", in_ready, ((DEPTH - n) >= 2));
            chk("wbq_empty", wbq_empty, (n == 0));
            chk("arf_1_we", arf_1_we, (n >= 1));
            chk("arf_2_we", arf_2_we, e2);
            if (n >= 1) begin
                chk("arf_1_waddr", arf_1_waddr, q[0].a);
                chk("arf_1_wdat", arf_1_wdat, q[0].d);
            end else begin
                chk("empty_waddr", arf_1_waddr, 0);
                chk("empty_wdat", arf_1_wdat, 0);
            end
            if (e2) begin
                chk("arf_2_waddr", arf_2_waddr, q[1].a);
                chk("arf_2_wdat", arf_2_wdat, q[1].d);
            end else begin
                chk("arf_2_known", $isunknown({arf_2_waddr, arf_2_wdat}), 0);
            end
            if (!rst) begin
                if (arf_1_we) reg_dut[arf_1_waddr] = arf_1_wdat;
                if (arf_2_we) reg_dut[arf_2_waddr] = arf_2_wdat;
            end
        end
    end

    task automatic set_in(input bit v1, input int a1, input int d1,
                          input bit v2, input int a2, input int d2);
        in_1_valid = v1; in_1_addr = AW'(a1); in_1_dat = DW'(d1);
        in_2_valid = v2; in_2_addr = AW'(a2); in_2_dat = DW'(d2);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ports(input string tag, input bit w1, input int a1, input int d1, input bit w2);
        chk({tag, "_we1"}, arf_1_we, w1);
        chk({tag, "_addr1"}, arf_1_waddr, a1);
        chk({tag, "_dat1"}, arf_1_wdat, d1);
        chk({tag, "_we2"}, arf_2_we, w2);
    endtask

    initial begin
        for (int r = 0; r < 32; r++) begin
            reg_exp[r] = '0;
            reg_dut[r] = '0;
        end
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0);
        tick();
        en = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", in_ready, 1);
        chk("rst_empty", wbq_empty, 1);
        chk_ports("rst", 0, 0, 0, 0);
        tick();

        // Two distinct registers drain together one cycle after acceptance.
        set_in(1, 3, 'hA, 1, 4, 'hB);
        tick();
        set_in(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk_ports("pair", 1, 3, 'hA, 1);
        chk("pair_addr2", arf_2_waddr, 4);
        chk("pair_dat2", arf_2_wdat, 'hB);
        @(negedge clk);
        chk_ports("pair_done", 0, 0, 0, 0);
        chk("pair_empty", wbq_empty, 1);
        tick();

        // Same-register pair drains older first, one per cycle.
        set_in(1, 5, 1, 1, 5, 2);
        tick();
        set_in(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk_ports("waw_c1", 1, 5, 1, 0);
        @(negedge clk);
        chk_ports("waw_c2", 1, 5, 2, 0);
        @(negedge clk);
        chk("waw_empty", wbq_empty, 1);
        tick();
        chk("waw_r5", reg_dut[5], 2);

        // Nil-register slot is swallowed; the other slot becomes the only entry.
        set_in(1, 0, 'hFF, 1, 7, 9);
        tick();
        set_in(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk_ports("nil", 1, 7, 9, 0);
        @(negedge clk);
        chk("nil_empty", wbq_empty, 1);
        tick();

        // Back-to-back same-register pairs: occupancy 2 then 3, crossing the pointer wrap.
        set_in(1, 6, 1, 1, 6, 2);
        tick();
        set_in(1, 6, 3, 1, 6, 4);
        @(negedge clk);
        chk("fill_ready2", in_ready, 1);
        chk_ports("fill_c1", 1, 6, 1, 0);
        tick();
        set_in(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("fill_ready3", in_ready, 0);
        chk_ports("fill_c2", 1, 6, 2, 0);
        @(negedge clk);
        chk_ports("fill_c3", 1, 6, 3, 0);
        @(negedge clk);
        chk_ports("fill_c4", 1, 6, 4, 0);
        @(negedge clk);
        chk("fill_empty", wbq_empty, 1);
        tick();

        // Reset with three entries held and fresh inputs offered in the same cycle.
        set_in(1, 10, 1, 1, 10, 2);
        tick();
        set_in(1, 10, 3, 1, 10, 4);
        tick();
        rst = 1'b1;
        set_in(1, 11, 'h55, 1, 12, 'h66);
        tick();
        rst = 1'b0;
        set_in(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("rstq_empty", wbq_empty, 1);
        chk("rstq_ready", in_ready, 1);
        chk_ports("rstq", 0, 0, 0, 0);
        tick();
        tick();
        chk("rstq_r10", reg_dut[10], 1);
        chk("rstq_r11", reg_dut[11], 0);
        chk("rstq_r12", reg_dut[12], 0);

        for (int i = 0; i < 10000; i++) begin
            rst = ($urandom_range(0, 499) == 0);
            set_in($urandom_range(0, 1), $urandom_range(0, 7), $urandom,
                   $urandom_range(0, 1), $urandom_range(0, 7), $urandom);
            tick();
        end
        rst = 1'b0;
        set_in(0, 0, 0, 0, 0, 0);
        repeat (8) tick();
        @(negedge clk);
        chk("drain_empty", wbq_empty, 1);
        tick();
        for (int r = 0; r < 32; r++)
            chk($sformatf("regfile_r%0d", r), reg_dut[r], reg_exp[r]);
        chk("r0_untouched", reg_dut[0], 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
